// File: rtl/display_timings_480p_if.sv
// Video timing bus carrying raster position, syncs, data enable and line/frame strobes.
// The timing generator drives the master side; paint and colour logic read the slave side.
interface display_timings_480p_if #(
  parameter int CORDW = 10
);
  logic [CORDW-1:0] sx;
  logic [CORDW-1:0] sy;
  logic             hsync;
  logic             vsync;
  logic             de;
  logic             line;
  logic             frame;

  modport master (
    output sx, sy, hsync, vsync, de, line, frame
  );

  modport slave (
    input sx, sy, hsync, vsync, de, line, frame
  );
endinterface

// File: rtl/display_timings_480p.sv
// Display timing generator, 640x480 at 60 Hz by default (800x525 total); all outputs registered and aligned.
// Optional clock enable input clk_en is added when DISPLAY_TIMINGS_CE_EN is defined.
module display_timings_480p #(
  parameter int   CORDW  = 10,
  parameter int   H_RES  = 640,
  parameter int   H_FP   = 16,
  parameter int   H_SYNC = 96,
  parameter int   H_BP   = 48,
  parameter int   V_RES  = 480,
  parameter int   V_FP   = 10,
  parameter int   V_SYNC = 2,
  parameter int   V_BP   = 33,
  parameter logic H_POL  = 1'b0,
  parameter logic V_POL  = 1'b0
) (
  input  logic                   clk_pix,
  input  logic                   rst_pix,
`ifdef DISPLAY_TIMINGS_CE_EN
  input  logic                   clk_en,
`endif
  display_timings_480p_if.master vid
);

  localparam int H_TOTAL   = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_RES + V_FP + V_SYNC + V_BP;
  localparam int CORD_SPAN = 2 ** CORDW;

  localparam logic [CORDW-1:0] H_LAST   = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST   = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_ACT    = CORDW'(H_RES);
  localparam logic [CORDW-1:0] V_ACT    = CORDW'(V_RES);
  localparam logic [CORDW-1:0] HS_START = CORDW'(H_RES + H_FP);
  localparam logic [CORDW-1:0] HS_END   = CORDW'(H_RES + H_FP + H_SYNC);
  localparam logic [CORDW-1:0] VS_START = CORDW'(V_RES + V_FP);
  localparam logic [CORDW-1:0] VS_END   = CORDW'(V_RES + V_FP + V_SYNC);

  // Coordinates must be able to hold the last position of each axis.
  if (CORD_SPAN < H_TOTAL || CORD_SPAN < V_TOTAL) begin : g_cordw_too_small
    $error("display_timings_480p: 2**CORDW (%0d) is smaller than H_TOTAL (%0d) or V_TOTAL (%0d)",
           CORD_SPAN, H_TOTAL, V_TOTAL);
  end

  logic advance;
`ifdef DISPLAY_TIMINGS_CE_EN
  assign advance = clk_en;
`else
  assign advance = 1'b1;
`endif

  logic [CORDW-1:0] sx_q;
  logic [CORDW-1:0] sy_q;
  logic             hsync_q;
  logic             vsync_q;
  logic             de_q;
  logic             line_q;
  logic             frame_q;

  logic [CORDW-1:0] x_next;
  logic [CORDW-1:0] y_next;
  logic             de_next;
  logic             hs_active;
  logic             vs_active;

  // Next raster position plus its decode; registering these keeps every output
  // describing the coordinates visible in the same cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    x_next = sx_q + 1'b1;
    y_next = sy_q;
    if (sx_q == H_LAST) begin
      x_next = '0;
      y_next = (sy_q == V_LAST) ? '0 : sy_q + 1'b1;
    end
    de_next   = (x_next < H_ACT) && (y_next < V_ACT);
    hs_active = (x_next >= HS_START) && (x_next < HS_END);
    vs_active = (y_next >= VS_START) && (y_next < VS_END);
  end

  always_ff @(posedge clk_pix) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_pix) begin
      sx_q    <= H_LAST;
      sy_q    <= V_LAST;
      hsync_q <= ~H_POL;
      vsync_q <= ~V_POL;
      de_q    <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else if (advance) begin
      sx_q    <= x_next;
      sy_q    <= y_next;
      hsync_q <= hs_active ? H_POL : ~H_POL;
      vsync_q <= vs_active ? V_POL : ~V_POL;
      de_q    <= de_next;
      line_q  <= (x_next == '0);
      frame_q <= (x_next == '0) && (y_next == '0);
    end else begin
      // Position holds while disabled, but strobes must not stretch beyond one clk_pix cycle.
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end
  end

  assign vid.sx    = sx_q;
  assign vid.sy    = sy_q;
  assign vid.hsync = hsync_q;
  assign vid.vsync = vsync_q;
  assign vid.de    = de_q;
  assign vid.line  = line_q;
  assign vid.frame = frame_q;

endmodule
